serializer: RTL and testbench

SERIALIZER -- requirements
Module: serializer

---
 rtl/serial_pkg.sv | 14 +
 rtl/serializer.sv | 116 +++++++++++
 tb/tb_serializer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial link blocks (serializer / deserializer).
package serial_pkg;

  // Default parallel word width used by both ends of the link.
  localparam int DEFAULT_DATA_WIDTH = 8;

  // Serializer control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/serializer.sv
// Parallel-to-serial converter with a one-word holding register.
// Upstream hands over words with a valid/ack handshake; the word is copied
// into a shift register and sent one bit per cycle whenever the downstream
// side is ready. One idle strobe cycle (GAP) separates consecutive words.
module serializer
  import serial_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clock_100KHZ,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid_in,
  output logic                  ack_out,
  input  logic                  ready_in,
  output logic                  data_out,
  output logic                  write_out,
  output logic                  status_out,
  output logic                  pending_out
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  state_t                 state;
  logic [DATA_WIDTH-1:0]  hold;
  logic [DATA_WIDTH-1:0]  shift;
  logic                   hold_full;
  logic [IDX_W-1:0]       index;
  logic [IDX_W-1:0]       bit_pos;
  logic                   cur_bit;
  logic                   capture;

  // A cycle that is already acknowledging never captures, so an upstream
  // valid that drops one cycle late cannot be taken twice.
  assign capture  = data_valid_in && !hold_full && !ack_out;

  // Bit order is fixed at elaboration; index always counts 0..DATA_WIDTH-1.
  assign bit_pos  = MSB_FIRST ? (LAST_IDX - index) : index;
  assign cur_bit  = shift[bit_pos];

  // The holding flag is itself a register, so it drives pending directly.
  assign pending_out = hold_full;

  // Handshake, holding register and send FSM with registered outputs.
  always_ff @(posedge clock_100KHZ) begin
    if (!reset) begin
      state      <= IDLE;
      hold_full  <= 1'b0;
      index      <= '0;
      ack_out    <= 1'b0;
      data_out   <= 1'b0;
      write_out  <= 1'b0;
      status_out <= 1'b0;
    end else begin
      ack_out   <= 1'b0;
      write_out <= 1'b0;

      case (state)
        IDLE: begin
          if (hold_full) begin
            shift      <= hold;
            hold_full  <= 1'b0;
            index      <= '0;
            state      <= SHIFT;
            status_out <= 1'b1;
          end else begin
            status_out <= 1'b0;
          end
        end

        SHIFT: begin
          status_out <= 1'b1;
          if (ready_in) begin
            data_out  <= cur_bit;
            write_out <= 1'b1;
            if (index == LAST_IDX) begin
              index <= '0;
              state <= GAP;
            end else begin
              index <= index + 1'b1;
            end
          end
        end

        GAP: begin
          if (hold_full) begin
            shift      <= hold;
            hold_full  <= 1'b0;
            index      <= '0;
            state      <= SHIFT;
            status_out <= 1'b1;
          end else begin
            state      <= IDLE;
            status_out <= 1'b0;
          end
        end

        default: begin
          state      <= IDLE;
          status_out <= 1'b0;
        end
      endcase

      // Capture only happens with the holding register empty, so it can
      // never collide with a reload in the same cycle.
      if (capture) begin
        hold      <= data_in;
        hold_full <= 1'b1;
        ack_out   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serializer.sv
// Directed bench for serializer: one MSB-first and one LSB-first instance
// share the stimulus; each is checked against hand-derived bit sequences.
`timescale 1ns/1ps
module tb_serializer;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       data_valid_in;
  logic       ready_in;

  logic ack_m, data_m, write_m, status_m, pending_m;
  logic ack_l, data_l, write_l, status_l, pending_l;

  int vectors;
  int miscompares;

  // monitor state, refreshed on every tick
  int          cyc;
  int          acks_m, acks_l;
  int          nstr_m, nstr_l;
  logic [15:0] bits_m, bits_l;
  int          str_q[$];

  serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clock_100KHZ (clk),
    .reset        (reset),
    .data_in      (data_in),
    .data_valid_in(data_valid_in),
    .ack_out      (ack_m),
    .ready_in     (ready_in),
    .data_out     (data_m),
    .write_out    (write_m),
    .status_out   (status_m),
    .pending_out  (pending_m)
  );

  serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clock_100KHZ (clk),
    .reset        (reset),
    .data_in      (data_in),
    .data_valid_in(data_valid_in),
    .ack_out      (ack_l),
    .ready_in     (ready_in),
    .data_out     (data_l),
    .write_out    (write_l),
    .status_out   (status_l),
    .pending_out  (pending_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    cyc    = 0;
    acks_m = 0;
    acks_l = 0;
    nstr_m = 0;
    nstr_l = 0;
    bits_m = '0;
    bits_l = '0;
    str_q.delete();
  endtask

  // one clock edge, then sample on the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (ack_m === 1'b1) acks_m++;
    if (ack_l === 1'b1) acks_l++;
    if (write_m === 1'b1) begin
      bits_m = {bits_m[14:0], data_m};
      nstr_m++;
      str_q.push_back(cyc);
    end
    if (write_l === 1'b1) begin
      bits_l = {bits_l[14:0], data_l};
      nstr_l++;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"},     {31'd0, ack_m | ack_l},         32'd0);
    chk({tag, "_data"},    {31'd0, data_m | data_l},       32'd0);
    chk({tag, "_write"},   {31'd0, write_m | write_l},     32'd0);
    chk({tag, "_status"},  {31'd0, status_m | status_l},   32'd0);
    chk({tag, "_pending"}, {31'd0, pending_m | pending_l}, 32'd0);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b0;
    data_in       = 8'h00;
    data_valid_in = 1'b0;
    ready_in      = 1'b0;
    clr();

    // ---- reset state
    ticks(2);
    chk_all_zero("reset");
    reset = 1'b1;
    ticks(1);

    // ---- 0xA5, ready always high
    clr();
    ready_in = 1'b1; data_in = 8'hA5; data_valid_in = 1'b1;
    tick();
    chk("a5_ack",      {31'd0, ack_m},     32'd1);
    chk("a5_pend",     {31'd0, pending_m}, 32'd1);
    data_valid_in = 1'b0;
    tick();
    chk("a5_status",   {31'd0, status_m},  32'd1);
    chk("a5_pend_clr", {31'd0, pending_m}, 32'd0);
    ticks(11);
    chk("a5_acks_m",   acks_m, 32'd1);
    chk("a5_acks_l",   acks_l, 32'd1);
    chk("a5_nstr_m",   nstr_m, 32'd8);
    chk("a5_bits_m",   {16'd0, bits_m}, 32'h00A5);
    chk("a5_bits_l",   {16'd0, bits_l}, 32'h00A5);
    chk("a5_first",    str_q[0], 32'd3);
    chk("a5_consec",   str_q[7] - str_q[0], 32'd7);
    chk("a5_idle_st",  {31'd0, status_m | status_l}, 32'd0);
    chk("a5_hold_dat", {31'd0, data_m}, 32'd1);

    // ---- 0x01: MSB-first ends on the 1, LSB-first starts with it
    clr();
    data_in = 8'h01; data_valid_in = 1'b1;
    tick();
    data_valid_in = 1'b0;
    ticks(12);
    chk("w01_bits_m",  {16'd0, bits_m}, 32'h0001);
    chk("w01_bits_l",  {16'd0, bits_l}, 32'h0080);
    chk("w01_nstr_l",  nstr_l, 32'd8);
    chk("w01_dat_m",   {31'd0, data_m}, 32'd1);
    chk("w01_dat_l",   {31'd0, data_l}, 32'd0);

    // ---- back-to-back 0x3C then 0xC3
    clr();
    data_in = 8'h3C; data_valid_in = 1'b1;
    tick();
    chk("b2b_ack1",    {31'd0, ack_m}, 32'd1);
    data_in = 8'hC3;
    tick();
    tick();
    chk("b2b_ack2",    {31'd0, ack_m}, 32'd1);
    chk("b2b_pend",    {31'd0, pending_m & status_m}, 32'd1);
    data_valid_in = 1'b0;
    ticks(20);
    chk("b2b_acks",    acks_m, 32'd2);
    chk("b2b_nstr",    nstr_m, 32'd16);
    chk("b2b_bits_m",  {16'd0, bits_m}, 32'h3CC3);
    chk("b2b_bits_l",  {16'd0, bits_l}, 32'h3CC3);
    chk("b2b_gap",     str_q[8] - str_q[7], 32'd2);
    chk("b2b_period",  str_q[8] - str_q[0], 32'd9);
    chk("b2b_span",    str_q[15] - str_q[0], 32'd16);

    // ---- 0xF0 with a 3-cycle stall after bit 2
    clr();
    data_in = 8'hF0; data_valid_in = 1'b1;
    tick();
    data_valid_in = 1'b0;
    ticks(4);
    chk("stl_pre",     nstr_m, 32'd3);
    ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stl_write", {31'd0, write_m | write_l}, 32'd0);
      chk("stl_dat_m", {31'd0, data_m}, 32'd1);
      chk("stl_dat_l", {31'd0, data_l}, 32'd0);
    end
    ready_in = 1'b1;
    ticks(8);
    chk("stl_nstr_m",  nstr_m, 32'd8);
    chk("stl_nstr_l",  nstr_l, 32'd8);
    chk("stl_bits_m",  {16'd0, bits_m}, 32'h00F0);
    chk("stl_bits_l",  {16'd0, bits_l}, 32'h000F);

    // ---- reset in the middle of 0xFF with 0x11 waiting
    clr();
    data_in = 8'hFF; data_valid_in = 1'b1;
    tick();
    data_in = 8'h11;
    tick();
    tick();
    chk("rst_ack2",    {31'd0, ack_m}, 32'd1);
    data_valid_in = 1'b0;
    ticks(4);
    chk("rst_nstr",    nstr_m, 32'd5);
    chk("rst_pend",    {31'd0, pending_m}, 32'd1);
    reset = 1'b0;
    ready_in = 1'b1;
    tick();
    chk_all_zero("rst_mid");
    reset = 1'b1;
    clr();
    ticks(25);
    chk("rst_no_str",  nstr_m + nstr_l, 32'd0);
    chk("rst_no_ack",  acks_m + acks_l, 32'd0);
    chk("rst_st",      {31'd0, status_m | pending_m}, 32'd0);

    // ---- valid held two cycles for a single word
    clr();
    data_in = 8'h5A; data_valid_in = 1'b1;
    tick();
    tick();
    data_valid_in = 1'b0;
    ticks(14);
    chk("dbl_acks",    acks_m, 32'd1);
    chk("dbl_nstr",    nstr_m, 32'd8);
    chk("dbl_bits_m",  {16'd0, bits_m}, 32'h005A);
    chk("dbl_bits_l",  {16'd0, bits_l}, 32'h005A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
